// File: rtl/nand_idelay_tap_ctrl.sv
// IODELAY tap sequencer for the NAND PHY lanes: waits for IDELAYCTRL ready, then steps one lane at a time.
// Optional `NAND_TAP_CTRL_WRAP_EN selects shortest modular stepping instead of linear stepping.
module nand_idelay_tap_ctrl #(
    parameter int NUM_LANES  = 8,
    parameter int TAP_W      = 5,
    parameter int LANE_W     = 4,
    parameter int SETTLE_CYC = 4
) (
    input  logic                       clk0,
    input  logic                       rstn0,
    input  logic                       idelay_ctrl_rdy,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [LANE_W-1:0]          req_lane,
    input  logic [TAP_W-1:0]           req_tap,
    output logic [NUM_LANES-1:0]       dly_ce,
    output logic [NUM_LANES-1:0]       dly_inc,
    output logic [NUM_LANES-1:0]       dly_rst,
    output logic [NUM_LANES*TAP_W-1:0] tap_cur,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [LANE_W:0] NL = (LANE_W + 1)'(NUM_LANES);

    typedef enum logic [2:0] {
        WAIT_RDY, INIT, IDLE, STEP, SETTLE, DONE
    } state_t;

    state_t            state, state_nx;
    logic              rdy_m, rdy_s;
    logic [LANE_W-1:0] lane_q;
    logic [TAP_W-1:0]  tgt_q, cur, tap_nx;
    logic [TAP_W-1:0]  tap_q [NUM_LANES];
    logic [CNT_W-1:0]  cnt;
    logic              lane_ok, up, step_ce, abort, abort_q;

    always_ff @(posedge clk0 or negedge rstn0) begin
        if (!rstn0) begin
            rdy_m <= 1'b0;
            rdy_s <= 1'b0;
        end else begin
            rdy_m <= idelay_ctrl_rdy;
            rdy_s <= rdy_m;
        end
    end

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (lane_q == LANE_W'(i)) cur = tap_q[i];
    end

    assign lane_ok = ({1'b0, lane_q} < NL);

`ifdef NAND_TAP_CTRL_WRAP_EN
    localparam logic [TAP_W-1:0] HALF = {1'b1, {(TAP_W-1){1'b0}}};
    logic [TAP_W-1:0] diff;
    // forward distance of at most half the ring goes up; the exact half ties upward
    assign diff = tgt_q - cur;
    assign up   = !diff[TAP_W-1] || (diff == HALF);
`else
    assign up = (tgt_q > cur);
`endif

    assign tap_nx = up ? cur + TAP_W'(1) : cur - TAP_W'(1);
    assign abort  = (state == STEP || state == SETTLE || state == DONE) && !rdy_s;

    always_comb begin
        state_nx  = state;
        step_ce   = 1'b0;
        req_ready = 1'b0;
        done      = 1'b0;
        err       = abort_q;
        dly_rst   = '0;
        case (state)
            WAIT_RDY: if (rdy_s) state_nx = INIT;
            INIT: begin
                dly_rst  = '1;
                state_nx = rdy_s ? IDLE : WAIT_RDY;
            end
            IDLE: begin
                req_ready = rdy_s;
                if (!rdy_s)         state_nx = WAIT_RDY;
                else if (req_valid) state_nx = STEP;
            end
            STEP: begin
                if (!rdy_s) state_nx = WAIT_RDY;
                else if (!lane_ok || cur == tgt_q) state_nx = DONE;
                else begin
                    step_ce  = 1'b1;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (!rdy_s) state_nx = WAIT_RDY;
                else if (cnt == CNT_W'(SETTLE_CYC - 1)) state_nx = STEP;
            end
            DONE: begin
                if (!rdy_s) state_nx = WAIT_RDY;
                else begin
                    done     = 1'b1;
                    err      = !lane_ok;
                    state_nx = IDLE;
                end
            end
            default: state_nx = WAIT_RDY;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            dly_ce[i]  = step_ce && (lane_q == LANE_W'(i));
            dly_inc[i] = dly_ce[i] && up;
            tap_cur[i*TAP_W +: TAP_W] = tap_q[i];
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk0 or negedge rstn0) begin
        if (!rstn0) begin
            state   <= WAIT_RDY;
            lane_q  <= '0;
            tgt_q   <= '0;
            cnt     <= '0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_nx;
            abort_q <= abort;
            cnt     <= (state == SETTLE) ? cnt + CNT_W'(1) : '0;
            if (state == IDLE && req_valid && req_ready) begin
                lane_q <= req_lane;
                tgt_q  <= req_tap;
            end
        end
    end

    always_ff @(posedge clk0 or negedge rstn0) begin
        if (!rstn0) begin
            for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (state == INIT)
                    tap_q[i] <= '0;
                else if (step_ce && lane_q == LANE_W'(i))
                    tap_q[i] <= tap_nx;
            end
        end
    end
endmodule

// File: tb/tb_nand_idelay_tap_ctrl.sv
// Bench for nand_idelay_tap_ctrl: per-cycle model of request traces plus directed init/abort checks.
// Build with +define+NAND_TAP_CTRL_WRAP_EN to exercise the shortest-path stepping variant.
module tb_nand_idelay_tap_ctrl;
    logic        clk0 = 1'b0;
    logic        rstn0, idelay_ctrl_rdy, req_valid, req_ready;
    logic [3:0]  req_lane;
    logic [4:0]  req_tap;
    logic [7:0]  dly_ce, dly_inc, dly_rst;
    logic [39:0] tap_cur;
    logic        busy, done, err;

    nand_idelay_tap_ctrl dut (
        .clk0(clk0), .rstn0(rstn0), .idelay_ctrl_rdy(idelay_ctrl_rdy),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_lane(req_lane), .req_tap(req_tap),
        .dly_ce(dly_ce), .dly_inc(dly_inc), .dly_rst(dly_rst),
        .tap_cur(tap_cur), .busy(busy), .done(done), .err(err)
    );

    always #5 clk0 = ~clk0;

    typedef struct packed {
        logic [7:0] ce;
        logic [7:0] inc;
        logic       done;
        logic       err;
        logic       busy;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    exp_t cr;
    int   mtap[8];
    int   total = 0, bad = 0;
    bit   chk_en = 0;
    int   cyc = 0, acc = 0, done_edge = 0;
    int   ce_cnt = 0, inc_cnt = 0, err_cnt = 0, done_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d", nm, a, e, cyc);
        end
    endtask

    function automatic logic [39:0] mflat();
        logic [39:0] f;
        int v;
        for (int i = 0; i < 8; i++) begin
            v = mtap[i];
            f[i*5 +: 5] = v[4:0];
        end
        return f;
    endfunction

    always @(posedge clk0) cyc <= cyc + 1;

    always @(negedge clk0) begin
        if (dly_ce != 0) ce_cnt++;
        if (dly_inc != 0) inc_cnt++;
        if (err) err_cnt++;
        if (done) begin
            done_cnt++;
            done_edge = cyc + 1;
        end
    end

    always @(negedge clk0) begin
        if (chk_en) begin
            if (exp_q.size() > 0) cr = exp_q.pop_front();
            else cr = '{ce: 8'h0, inc: 8'h0, done: 1'b0, err: 1'b0, busy: 1'b0, ready: 1'b1};
            chk("ce", dly_ce, cr.ce);
            chk("inc", dly_inc, cr.inc);
            chk("rst", dly_rst, 8'h00);
            chk("done", done, cr.done);
            chk("err", err, cr.err);
            chk("busy", busy, cr.busy);
            chk("ready", req_ready, cr.ready);
            chk("tap_cur", tap_cur, mflat());
            for (int i = 0; i < 8; i++)
                if (cr.ce[i]) mtap[i] = cr.inc[i] ? (mtap[i] + 1) % 32 : (mtap[i] + 31) % 32;
        end
    end

    task automatic do_req(input int lane, input int tap);
        int cur, d, fwd;
        bit up, bl;
        exp_t r;
        @(negedge clk0);
        req_valid = 1'b1;
        req_lane  = 4'(lane);
        req_tap   = 5'(tap);
        @(posedge clk0);
        bl  = (lane >= 8);
        cur = bl ? 0 : mtap[lane];
`ifdef NAND_TAP_CTRL_WRAP_EN
        fwd = (tap - cur + 32) % 32;
        up  = (fwd <= 16);
        d   = up ? fwd : 32 - fwd;
`else
        fwd = 0;
        up  = (tap > cur);
        d   = up ? tap - cur : cur - tap;
`endif
        if (bl) d = 0;
        for (int t = 0; t <= d * 5 + 1; t++) begin
            r = '0;
            r.busy = 1'b1;
            if (t < d * 5 && t % 5 == 0) begin
                r.ce = 8'(1 << lane);
                if (up) r.inc = r.ce;
            end
            if (t == d * 5 + 1) begin
                r.done = 1'b1;
                r.err  = bl;
            end
            exp_q.push_back(r);
        end
        #1;
        req_valid = 1'b0;
        acc = cyc;
        ce_cnt = 0; inc_cnt = 0; err_cnt = 0; done_cnt = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk0);
            #1;
            n++;
        end
        chk("req_timeout", exp_q.size() == 0, 1'b1);
        @(negedge clk0);
        #1;
    endtask

    task automatic rdy_up();
        @(posedge clk0);
        #1 idelay_ctrl_rdy = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk0);
            chk("init_rst", dly_rst, (k == 4) ? 8'hFF : 8'h00);
            chk("init_ready", req_ready, k >= 5);
        end
        chk("init_tap", tap_cur, 40'h0);
        for (int i = 0; i < 8; i++) mtap[i] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rstn0 = 1'b0;
        idelay_ctrl_rdy = 1'b0;
        req_valid = 1'b0;
        req_lane = '0;
        req_tap = '0;
        for (int i = 0; i < 8; i++) mtap[i] = 0;
        repeat (3) @(negedge clk0);
        chk("rst_ce", dly_ce, 8'h00);
        chk("rst_inc", dly_inc, 8'h00);
        chk("rst_rst", dly_rst, 8'h00);
        chk("rst_tap", tap_cur, 40'h0);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rstn0 = 1'b1;
        repeat (10) @(posedge clk0);
        rdy_up();
        chk_en = 1'b1;

        do_req(2, 3);
        wait_done();
        chk("t2_lat", done_edge - acc, 17);
        chk("t2_ce", ce_cnt, 3);
        chk("t2_inc", inc_cnt, 3);
        chk("t2_tap", tap_cur[14:10], 5'd3);

        do_req(2, 1);
        wait_done();
        chk("t3_lat", done_edge - acc, 12);
        chk("t3_ce", ce_cnt, 2);
        chk("t3_inc", inc_cnt, 0);
        chk("t3_tap", tap_cur[14:10], 5'd1);

        do_req(9, 7);
        wait_done();
        chk("t4a_lat", done_edge - acc, 2);
        chk("t4a_err", err_cnt, 1);
        chk("t4a_ce", ce_cnt, 0);

        do_req(5, 0);
        wait_done();
        chk("t4b_lat", done_edge - acc, 2);
        chk("t4b_err", err_cnt, 0);
        chk("t4b_ce", ce_cnt, 0);

        do_req(0, 20);
        for (int n = 0; n < 100 && ce_cnt < 2; n++) begin
            @(negedge clk0);
            #1;
        end
        chk("t5_ce_seen", ce_cnt, 2);
        chk_en = 1'b0;
        exp_q.delete();
        idelay_ctrl_rdy = 1'b0;
        ce_cnt = 0; err_cnt = 0; done_cnt = 0;
        repeat (12) @(negedge clk0);
        #1;
        chk("t5_ce", ce_cnt, 0);
        chk("t5_err", err_cnt, 1);
        chk("t5_done", done_cnt, 0);
        chk("t5_hold", tap_cur[4:0], 5'd2);
        chk("t5_busy", busy, 1'b1);
        chk("t5_ready", req_ready, 1'b0);
        rdy_up();
        chk_en = 1'b1;

        do_req(0, 30);
        wait_done();
`ifdef NAND_TAP_CTRL_WRAP_EN
        chk("t6_lat", done_edge - acc, 12);
        chk("t6_ce", ce_cnt, 2);
        chk("t6_inc", inc_cnt, 0);
`else
        chk("t6_lat", done_edge - acc, 152);
        chk("t6_ce", ce_cnt, 30);
        chk("t6_inc", inc_cnt, 30);
`endif
        chk("t6_tap", tap_cur[4:0], 5'd30);

        do_req(3, 10);
        repeat (7) @(negedge clk0);
        #1;
        chk_en = 1'b0;
        rstn0 = 1'b0;
        #1;
        chk("arst_ce", dly_ce, 8'h00);
        chk("arst_inc", dly_inc, 8'h00);
        chk("arst_tap", tap_cur, 40'h0);
        chk("arst_busy", busy, 1'b1);
        chk("arst_ready", req_ready, 1'b0);
        chk("arst_done", {done, err}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
